// File: rtl/cs_tick_gen_if.sv
// Centisecond tick generator signal bundle.
// master drives PPS and enable; slave is the generator.
interface cs_tick_gen_if;
    logic pps;
    logic pps_en;
    logic cs_tick;
    logic sec_align;
    logic locked;
    logic slip;

    modport master (
        output pps,
        output pps_en,
        input  cs_tick,
        input  sec_align,
        input  locked,
        input  slip
    );

    modport slave (
        input  pps,
        input  pps_en,
        output cs_tick,
        output sec_align,
        output locked,
        output slip
    );
endinterface

// File: rtl/cs_tick_gen.sv
// Centisecond tick enable with optional PPS discipline.
// Free-running prescaler realigned by PPS edges; tracks lock and slip.
module cs_tick_gen #(
    parameter int DIV     = 100,
    parameter int TIMEOUT = 3
) (
    input logic          clk,
    input logic          rst,
    cs_tick_gen_if.slave bus
);
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(DIV - 1);
    localparam logic [2:0] MISS_LIM = 3'(TIMEOUT);

    typedef enum logic {
        FREE,
        LOCKED
    } state_t;

    state_t state;

    logic s1;
    logic s2;
    logic s3;
    logic [CNT_W-1:0] presc;
    logic [6:0] cs_cnt;
    logic seen;
    logic [2:0] miss;
    logic [2:0] miss_inc;
    logic pps_rise;
    logic presc_wrap;
    logic wrap99;
    logic in_window;
    logic cs_tick_q;
    logic sec_align_q;
    logic locked_q;
    logic slip_q;

    assign pps_rise   = s2 & ~s3 & bus.pps_en;
    assign presc_wrap = (presc == PRESC_MAX);
    assign wrap99     = presc_wrap & (cs_cnt == 7'd99);
    assign in_window  = (cs_cnt == 7'd99) | (cs_cnt == 7'd0);
    assign miss_inc   = (miss == 3'd7) ? 3'd7 : miss + 3'd1;

    assign bus.cs_tick   = cs_tick_q;
    assign bus.sec_align = sec_align_q;
    assign bus.locked    = locked_q;
    assign bus.slip      = slip_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.pps;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A PPS edge replaces the tick it lands on; the timebase restarts at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc     <= '0;
            cs_cnt    <= '0;
            cs_tick_q <= 1'b0;
        end else begin
            cs_tick_q <= presc_wrap & ~pps_rise;
            if (pps_rise) begin
                presc  <= '0;
                cs_cnt <= '0;
            end else if (presc_wrap) begin
                presc  <= '0;
                cs_cnt <= (cs_cnt == 7'd99) ? 7'd0 : cs_cnt + 7'd1;
            end else begin
                presc <= presc + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FREE;
            locked_q    <= 1'b0;
            slip_q      <= 1'b0;
            seen        <= 1'b0;
            miss        <= '0;
            sec_align_q <= 1'b0;
        end else begin
            sec_align_q <= pps_rise;
            if (!bus.pps_en) begin
                state    <= FREE;
                locked_q <= 1'b0;
                slip_q   <= 1'b0;
                seen     <= 1'b0;
                miss     <= '0;
            end else if (pps_rise) begin
                seen     <= 1'b1;
                state    <= LOCKED;
                locked_q <= 1'b1;
                if (state == LOCKED && !in_window) begin
                    slip_q <= 1'b1;
                end
            end else if (wrap99) begin
                seen <= 1'b0;
                miss <= seen ? 3'd0 : miss_inc;
                // Drop lock on the boundary where the miss count reaches the limit.
                if (state == LOCKED && !seen && miss_inc >= MISS_LIM) begin
                    state    <= FREE;
                    locked_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cs_tick_gen.sv
// Directed bench for cs_tick_gen with DIV=4, TIMEOUT=3.
// Edge numbers count posedges since the last reset release.
module tb_cs_tick_gen;
    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   n_tick;
    int   n_align;
    int   last_ev;
    int   bad_gap;
    bit   mon_on;

    cs_tick_gen_if bus ();

    cs_tick_gen #(
        .DIV    (4),
        .TIMEOUT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            n_tick  += int'(bus.cs_tick);
            n_align += int'(bus.sec_align);
            if (bus.cs_tick || bus.sec_align) begin
                if (mon_on && last_ev != 0 && cyc - last_ev != 4) bad_gap++;
                last_ev = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Leaves pps high across edges act-2 and act-1; realign lands at edge act.
    task automatic pps_pulse(input int act);
        run_to(act - 3);
        bus.pps = 1'b1;
        step();
        step();
        bus.pps = 1'b0;
    endtask

    task automatic clear_mon();
        n_tick  = 0;
        n_align = 0;
        last_ev = 0;
        bad_gap = 0;
    endtask

    function automatic logic [3:0] outs();
        return {bus.cs_tick, bus.sec_align, bus.locked, bus.slip};
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        mon_on = 1'b0;
        clear_mon();
        rst        = 1'b1;
        bus.pps    = 1'b0;
        bus.pps_en = 1'b1;
        #1 rst = 1'b0;
        #2 check("reset_async", 32'(outs()), 32'd0);
        repeat (3) @(negedge clk);
        check("reset_hold", 32'(outs()), 32'd0);
        rst = 1'b1;

        // Free run: ticks every 4th edge, never aligned or locked.
        for (int e = 1; e <= 12; e++) begin
            step();
            check($sformatf("t1_tick_e%0d", e), 32'(bus.cs_tick),
                  (e % 4 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t1_idle_e%0d", e),
                  32'({bus.sec_align, bus.locked, bus.slip}), 32'd0);
        end

        // PPS high before edge 13: realign at edge 15.
        bus.pps = 1'b1;
        step();
        check("t2_align_e13", 32'({bus.sec_align, bus.locked}), 32'd0);
        step();
        check("t2_align_e14", 32'({bus.sec_align, bus.locked}), 32'd0);
        step();
        check("t2_align_e15", 32'(outs()), 32'b0110);
        step();
        check("t2_align_e16", 32'(bus.sec_align), 32'd0);
        step();
        step();
        check("t2_tick_e18", 32'(bus.cs_tick), 32'd0);
        step();
        check("t2_tick_e19", 32'(bus.cs_tick), 32'd1);
        bus.pps = 1'b0;
        clear_mon();
        mon_on = 1'b1;

        // In-window PPS every 400 clks replaces the tick on the boundary.
        pps_pulse(415);
        step();
        check("t3_e415", 32'(outs()), 32'b0110);
        n_tick  = 0;
        n_align = 0;
        pps_pulse(815);
        step();
        check("t3_ticks", 32'(n_tick), 32'd99);
        check("t3_aligns", 32'(n_align), 32'd1);
        check("t3_gaps", 32'(bad_gap), 32'd0);
        check("t3_state", 32'({bus.locked, bus.slip}), 32'b10);
        mon_on = 1'b0;

        // Out-of-window PPS at cs_cnt=50.
        pps_pulse(1017);
        step();
        check("t4_e1017", 32'(outs()), 32'b0111);
        run_to(1021);
        check("t4_tick_e1021", 32'(bus.cs_tick), 32'd1);
        run_to(1030);
        check("t4_sticky", 32'({bus.locked, bus.slip}), 32'b11);
        bus.pps_en = 1'b0;
        step();
        check("t4_en_off", 32'({bus.locked, bus.slip}), 32'b00);
        bus.pps_en = 1'b1;
        run_to(1033);
        check("t4_en_on", 32'({bus.locked, bus.slip}), 32'b00);
        check("t4_presc_kept", 32'(bus.cs_tick), 32'd1);

        // Lock, then remove PPS: boundaries at 1500, 1900, 2300, 2700.
        pps_pulse(1100);
        step();
        check("t5_lock", 32'({bus.locked, bus.slip}), 32'b10);
        clear_mon();
        mon_on = 1'b1;
        run_to(2699);
        check("t5_still_locked", 32'(bus.locked), 32'd1);
        step();
        check("t5_unlock_e2700", 32'(bus.locked), 32'd0);
        run_to(2720);
        check("t5_ticks", 32'(n_tick), 32'd405);
        check("t5_aligns", 32'(n_align), 32'd0);
        check("t5_gaps", 32'(bad_gap), 32'd0);
        mon_on = 1'b0;

        // PPS lands exactly on presc==3.
        run_to(2796);
        check("t6_tick_e2796", 32'(bus.cs_tick), 32'd1);
        pps_pulse(2800);
        step();
        check("t6_e2800", 32'(outs()), 32'b0110);
        step();
        check("t6_e2801", 32'(bus.cs_tick), 32'd0);
        run_to(2804);
        check("t6_e2804", 32'(outs()), 32'b1010);

        // Mid-count reset clears outputs without waiting for a clock.
        #1 rst = 1'b0;
        #1 check("t6_async_rst", 32'(outs()), 32'd0);
        repeat (2) @(negedge clk);
        check("t6_rst_hold", 32'(outs()), 32'd0);
        rst = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            check($sformatf("t6_restart_e%0d", e), 32'(outs()),
                  (e == 4) ? 32'b1000 : 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
